nr_divider: RTL and testbench



---
 rtl/nr_divider_if.sv | 30 +++
 rtl/nr_divider.sv | 100 ++++++++++
 tb/tb_nr_divider.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nr_divider_if.sv
// Start/busy/done handshake and operand/result bus for nr_divider.
// dz exists only when DIV_ZERO_FLAG_EN is defined.
interface nr_divider_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
   logic             dz;
`endif

   modport master (
      output start, dividend, divisor,
`ifdef DIV_ZERO_FLAG_EN
      input  dz,
`endif
      input  busy, done, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
`ifdef DIV_ZERO_FLAG_EN
      output dz,
`endif
      output busy, done, quotient, remainder
   );
endinterface

// File: rtl/nr_divider.sv
// Sequential unsigned non-restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_FLAG_EN: divide-by-zero early exit and dz flag.
module nr_divider #(
   parameter int WIDTH = 4
) (
   input logic        clk,
   input logic        rst,
   nr_divider_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   state_t           state, state_nxt;
   logic [WIDTH:0]   a, a_nxt, m, m_nxt;
   logic [WIDTH-1:0] q, q_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH:0]   add_a, sum;
   logic             mode;
   logic             fin;

   // Single shared adder/subtractor: mode=1 computes add_a - m.
   assign sum = add_a + (mode ? ~m : m) + {{WIDTH{1'b0}}, mode};

   always_comb begin
      state_nxt = state;
      a_nxt     = a;
      q_nxt     = q;
      m_nxt     = m;
      cnt_nxt   = cnt;
      add_a     = a;
      mode      = 1'b0;
      fin       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               a_nxt     = '0;
               q_nxt     = bus.dividend;
               m_nxt     = {1'b0, bus.divisor};
               cnt_nxt   = '0;
               state_nxt = ITER;
`ifdef DIV_ZERO_FLAG_EN
               // Preload the zero-divisor answer so FIX just publishes it.
               if (bus.divisor == '0) begin
                  q_nxt     = '1;
                  a_nxt     = {1'b0, bus.dividend};
                  state_nxt = FIX;
               end
`endif
            end
         end
         ITER: begin
            add_a = {a[WIDTH-1:0], q[WIDTH-1]};
            mode  = ~a[WIDTH];
            a_nxt = sum;
            q_nxt = {q[WIDTH-2:0], ~sum[WIDTH]};
            if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            else                       cnt_nxt   = cnt + 1'b1;
         end
         FIX: begin
            if (a[WIDTH]) a_nxt = sum;
            fin       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         a             <= '0;
         q             <= '0;
         m             <= '0;
         cnt           <= '0;
         bus.done      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
         bus.dz        <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         a        <= a_nxt;
         q        <= q_nxt;
         m        <= m_nxt;
         cnt      <= cnt_nxt;
         bus.done <= fin;
         if (fin) begin
            bus.quotient  <= q;
            bus.remainder <= a_nxt[WIDTH-1:0];
`ifdef DIV_ZERO_FLAG_EN
            bus.dz        <= (m == '0);
`endif
         end
      end
   end

   assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_nr_divider.sv
// Self-checking bench for nr_divider (WIDTH=4): directed table, corner
// sequences, exhaustive sweep and random operands against an arithmetic model.
module tb_nr_divider;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   nr_divider_if #(.WIDTH(W)) bif ();
   nr_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int lat_of(input logic [W-1:0] b);
`ifdef DIV_ZERO_FLAG_EN
      if (b == 0) return 1;
`endif
      return W + 1;
   endfunction

   // Starts an operation now (caller is mid-cycle) and waits for done.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input string tag);
      int cyc = 0;
      int ovl = 0;
      bif.start    = 1'b1;
      bif.dividend = a;
      bif.divisor  = b;
      @(posedge clk); #1;
      bif.start = 1'b0;
      chk({tag, " busy after accept"}, int'(bif.busy), 1);
      while (!bif.done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (bif.busy && bif.done) ovl = 1;
      end
      chk({tag, " latency"}, cyc, lat_of(b));
      chk({tag, " quotient"}, int'(bif.quotient), int'(eq));
      chk({tag, " remainder"}, int'(bif.remainder), int'(er));
      chk({tag, " busy&done overlap"}, ovl, 0);
`ifdef DIV_ZERO_FLAG_EN
      chk({tag, " dz"}, int'(bif.dz), (b == 0) ? 1 : 0);
`endif
   endtask

   vec_t tbl[7];

   initial begin
      int dones;
      int first;
      logic [W-1:0] ra, rb, mq, mr;

      tbl[0] = '{4'd13, 4'd4,  4'd3,  4'd1};
      tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0};
      tbl[2] = '{4'd3,  4'd7,  4'd0,  4'd3};
      tbl[3] = '{4'd15, 4'd15, 4'd1,  4'd0};
      tbl[4] = '{4'd9,  4'd0,  4'd15, 4'd9};
      tbl[5] = '{4'd0,  4'd5,  4'd0,  4'd0};
      tbl[6] = '{4'd14, 4'd3,  4'd4,  4'd2};

      bif.start = 1'b0; bif.dividend = '0; bif.divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", int'(bif.busy), 0);
      chk("reset done", int'(bif.done), 0);
      chk("reset quotient", int'(bif.quotient), 0);
      chk("reset remainder", int'(bif.remainder), 0);
`ifdef DIV_ZERO_FLAG_EN
      chk("reset dz", int'(bif.dz), 0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("tbl%0d", i));
         @(posedge clk); #1;
         chk($sformatf("tbl%0d done one cycle", i), int'(bif.done), 0);
         chk($sformatf("tbl%0d quotient held", i), int'(bif.quotient), int'(tbl[i].q));
      end

      // start pulsed while busy must be ignored
      bif.start = 1'b1; bif.dividend = 4'd13; bif.divisor = 4'd4;
      @(posedge clk); #1;
      bif.start = 1'b0;
      @(posedge clk); #1;
      bif.start = 1'b1; bif.dividend = 4'd8; bif.divisor = 4'd3;
      @(posedge clk); #1;
      bif.start = 1'b0;
      dones = 0; first = 0;
      for (int c = 3; c <= 12; c++) begin
         @(posedge clk); #1;
         if (bif.done) begin
            dones++;
            if (first == 0) first = c;
         end
      end
      chk("ignore done count", dones, 1);
      chk("ignore done cycle", first, 5);
      chk("ignore quotient", int'(bif.quotient), 3);
      chk("ignore remainder", int'(bif.remainder), 1);

      // start held on the done cycle is accepted
      run_op(4'd13, 4'd4, 4'd3, 4'd1, "b2b first");
      chk("b2b done high", int'(bif.done), 1);
      run_op(4'd8, 4'd3, 4'd2, 4'd2, "b2b second");

      // reset during iteration 2 aborts without done
      bif.start = 1'b1; bif.dividend = 4'd14; bif.divisor = 4'd5;
      @(posedge clk); #1;
      bif.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort busy", int'(bif.busy), 0);
      chk("abort done", int'(bif.done), 0);
      chk("abort quotient", int'(bif.quotient), 0);
      chk("abort remainder", int'(bif.remainder), 0);
      rst = 1'b0;
      dones = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bif.done) dones++;
      end
      chk("abort no done", dones, 0);
      run_op(4'd14, 4'd5, 4'd2, 4'd4, "after abort");

      // exhaustive sweep against plain arithmetic
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) begin
            mq = (b == 0) ? 4'hF : W'(a / b);
            mr = (b == 0) ? W'(a) : W'(a % b);
            run_op(W'(a), W'(b), mq, mr, $sformatf("sweep %0d/%0d", a, b));
         end

      // random operands with random idle gaps
      for (int i = 0; i < 60; i++) begin
         ra = W'($urandom_range(0, 15));
         rb = W'($urandom_range(0, 15));
         mq = (rb == 0) ? 4'hF : ra / rb;
         mr = (rb == 0) ? ra : ra % rb;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         run_op(ra, rb, mq, mr, $sformatf("rand %0d/%0d", ra, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
